input_requester: RTL and testbench

INPUT_REQUESTER -- requirements
Module: input_requester

---
 rtl/noc_pkg.sv | 49 ++++
 rtl/flit_fifo.sv | 56 +++++
 rtl/input_requester.sv | 184 ++++++++++++++++++
 tb/tb_input_requester.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, output port indices, default flit
// width, requester FSM states and the XY route function.
package noc_pkg;

    localparam int unsigned FLIT_W = 34;

    typedef enum logic [1:0] {
        FtBody   = 2'b00,
        FtHead   = 2'b01,
        FtTail   = 2'b10,
        FtSingle = 2'b11
    } flit_type_e;

    localparam logic [2:0] PortLocal = 3'd0;
    localparam logic [2:0] PortEast  = 3'd1;
    localparam logic [2:0] PortWest  = 3'd2;
    localparam logic [2:0] PortNorth = 3'd3;
    localparam logic [2:0] PortSouth = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StActive,
        StRelease
    } req_state_e;

    // XY routing: resolve X first, then Y, else deliver locally.
    // dest[3:2] is dx, dest[1:0] is dy.
    function automatic logic [2:0] xy_route(input logic [3:0] dest,
                                            input logic [1:0] x_cur,
                                            input logic [1:0] y_cur);
        logic [1:0] dx;
        logic [1:0] dy;
        dx = dest[3:2];
        dy = dest[1:0];
        if (dx > x_cur) begin
            return PortEast;
        end else if (dx < x_cur) begin
            return PortWest;
        end else if (dy > y_cur) begin
            return PortNorth;
        end else if (dy < y_cur) begin
            return PortSouth;
        end else begin
            return PortLocal;
        end
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous DEPTH x WIDTH flit FIFO with full/empty flags. Push and pop may
// occur in the same cycle; pointers wrap naturally since DEPTH is a power of two.
module flit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    // Storage array; no reset needed since empty masks stale entries.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy update; reset drops everything buffered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/input_requester.sv
// Router input port: buffers incoming flits, routes each packet by its head
// flit, requests the chosen output arbiter and forwards flits while granted.
module input_requester #(
    parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned X_CUR  = 1,
    parameter int unsigned Y_CUR  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic [4:0]        req,
    input  logic [4:0]        gnt,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic [2:0]        out_port,
    output logic              protocol_err
);

    import noc_pkg::*;

    localparam logic [1:0] XCur = 2'(X_CUR);
    localparam logic [1:0] YCur = 2'(Y_CUR);

    req_state_e        state_q, state_d;
    logic [2:0]        route_q, route_d;
    logic [4:0]        req_q, req_d;
    logic              out_valid_q, out_valid_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic [2:0]        out_port_q, out_port_d;
    logic              perr_q, perr_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [FLIT_W-1:0] front;
    logic              fifo_full;
    logic              fifo_empty;
    flit_type_e        front_type;
    logic              front_is_head;
    logic              gnt_hit;

    assign in_ready      = !fifo_full;
    assign fifo_push     = in_valid && in_ready;
    assign front_type    = flit_type_e'(front[FLIT_W-1 -: 2]);
    assign front_is_head = (front_type == FtHead) || (front_type == FtSingle);
    // Only the grant for our latched route matters; others are ignored.
    assign gnt_hit       = gnt[route_q];

    flit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (in_flit),
        .pop   (fifo_pop),
        .rdata (front),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && front_is_head) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (gnt_hit && !fifo_empty) begin
                    state_d = (front_type == FtSingle) ? StRelease : StActive;
                end
            end
            StActive: begin
                if (gnt_hit && !fifo_empty && front_type == FtTail) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: FIFO pop plus next values of the registered outputs.
    always_comb begin
        fifo_pop    = 1'b0;
        route_d     = route_q;
        req_d       = req_q;
        out_valid_d = 1'b0;
        out_flit_d  = out_flit_q;
        out_port_d  = out_port_q;
        perr_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    if (front_is_head) begin
                        route_d = xy_route(front[3:0], XCur, YCur);
                        req_d   = 5'b00001 << route_d;
                    end else begin
                        // Stray body/tail with no open packet: drop it.
                        fifo_pop = 1'b1;
                        perr_d   = 1'b1;
                    end
                end
            end
            StReq: begin
                if (gnt_hit && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    out_valid_d = 1'b1;
                    out_flit_d  = front;
                    out_port_d  = route_q;
                    if (front_type == FtSingle) begin
                        req_d = '0;
                    end
                end
            end
            StActive: begin
                if (gnt_hit && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    out_valid_d = 1'b1;
                    out_flit_d  = front;
                    out_port_d  = route_q;
                    if (front_is_head) begin
                        // A new head inside an open packet is demoted to body.
                        out_flit_d = {FtBody, front[FLIT_W-3:0]};
                        perr_d     = 1'b1;
                    end else if (front_type == FtTail) begin
                        req_d = '0;
                    end
                end
            end
            StRelease: begin
                req_d = '0;
            end
            default: begin
                req_d = '0;
            end
        endcase
    end

    // Route latch and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            route_q     <= PortLocal;
            req_q       <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_port_q  <= '0;
            perr_q      <= 1'b0;
        end else begin
            route_q     <= route_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_port_q  <= out_port_d;
            perr_q      <= perr_d;
        end
    end

    assign req          = req_q;
    assign out_valid    = out_valid_q;
    assign out_flit     = out_flit_q;
    assign out_port     = out_port_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_input_requester.sv
// Self-checking bench for input_requester with a registered arbiter model and
// a scoreboard of expected forwarded flits.
module tb_input_requester;

    localparam int unsigned W = 34;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_flit;
    logic         in_ready;
    logic [4:0]   req;
    logic [4:0]   gnt;
    logic         out_valid;
    logic [W-1:0] out_flit;
    logic [2:0]   out_port;
    logic         protocol_err;

    logic [4:0]   gnt_allow;
    int           errors = 0;
    int           checks = 0;

    logic [W-1:0] exp_flit_q[$];
    logic [2:0]   exp_port_q[$];
    logic [W-1:0] mon_f;
    logic [2:0]   mon_p;

    input_requester #(
        .FLIT_W (W),
        .DEPTH  (4),
        .X_CUR  (1),
        .Y_CUR  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_flit      (in_flit),
        .in_ready     (in_ready),
        .req          (req),
        .gnt          (gnt),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_port     (out_port),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    // Arbiter model: grant follows a sampled request by one cycle.
    always @(posedge clk) begin
        if (rst !== 1'b1) gnt <= '0;
        else              gnt <= req & gnt_allow;
    end

    // Scoreboard and req one-hot monitor.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1) begin
            checks++;
            if (exp_flit_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got flit %h port %0d, expected no output",
                         out_flit, out_port);
            end else begin
                mon_f = exp_flit_q.pop_front();
                mon_p = exp_port_q.pop_front();
                if (out_flit !== mon_f || out_port !== mon_p) begin
                    errors++;
                    $display("FAIL sb_flit: got flit %h port %0d, expected flit %h port %0d",
                             out_flit, out_port, mon_f, mon_p);
                end
            end
        end
        if (rst === 1'b1) begin
            checks++;
            if (!$onehot0(req)) begin
                errors++;
                $display("FAIL req_onehot: req=%b, expected one-hot or zero", req);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] mk(input logic [1:0] t, input logic [7:0] tag,
                                        input logic [3:0] dest);
        return {t, 20'h0, tag, dest};
    endfunction

    task automatic push_flit(input logic [W-1:0] f, input logic expect_out,
                             input logic [W-1:0] exp_f, input logic [2:0] port);
        @(negedge clk);
        in_valid = 1'b1;
        in_flit  = f;
        @(posedge clk);
        if (expect_out) begin
            exp_flit_q.push_back(exp_f);
            exp_port_q.push_back(port);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        gnt_allow = '0;
        in_valid  = 1'b1;
        in_flit   = mk(T_SINGLE, 8'hEE, 4'b0101);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (req !== 5'b0)    begin errors++; $display("FAIL rst_req: got %b want 00000", req); end
        if (out_valid !== 0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        if (out_flit !== '0) begin errors++; $display("FAIL rst_flit: got %h want 0", out_flit); end
        if (out_port !== 0)  begin errors++; $display("FAIL rst_port: got %0d want 0", out_port); end
        if (protocol_err !== 0) begin
            errors++; $display("FAIL rst_perr: got %b want 0", protocol_err);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        // The flit offered during reset must not have been stored.
        gnt_allow = '1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (req !== 5'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_push_ignored: req=%b out_valid=%b want 00000 0", req, out_valid);
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] f;
        gnt_allow = '1;
        f = mk(T_SINGLE, 8'h11, 4'b1001);
        push_flit(f, 1'b1, f, 3'd1);
        @(negedge clk);
        checks++;
        if (req !== 5'b0) begin errors++; $display("FAIL single_req0: got %b want 00000", req); end
        @(negedge clk);
        checks += 2;
        if (req !== 5'b00010) begin errors++; $display("FAIL single_req: got %b want 00010", req); end
        if (gnt !== 5'b0) begin errors++; $display("FAIL single_gnt0: got %b want 00000", gnt); end
        @(negedge clk);
        checks += 2;
        if (gnt[1] !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b want 1", gnt[1]); end
        if (out_valid !== 0) begin errors++; $display("FAIL single_early: got %b want 0", out_valid); end
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        if (out_port !== 3'd1) begin errors++; $display("FAIL single_port: got %0d want 1", out_port); end
        if (req !== 5'b0) begin errors++; $display("FAIL single_release: got %b want 00000", req); end
        @(negedge clk);
        checks++;
        if (out_valid !== 0 || req !== 5'b0) begin
            errors++;
            $display("FAIL single_after: out_valid=%b req=%b want 0 00000", out_valid, req);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_packet();
        logic [W-1:0] h, b, t;
        int k;
        gnt_allow = '1;
        h = mk(T_HEAD, 8'h21, 4'b0101);
        b = mk(T_BODY, 8'h22, 4'b0000);
        t = mk(T_TAIL, 8'h23, 4'b0000);
        push_flit(h, 1'b1, h, 3'd0);
        push_flit(b, 1'b1, b, 3'd0);
        push_flit(t, 1'b1, t, 3'd0);
        k = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pkt_timeout: no out_valid want 1"); end
        if (req !== 5'b00001) begin errors++; $display("FAIL pkt_req: got %b want 00001", req); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1) begin errors++; $display("FAIL pkt_valid2: got %b want 1", out_valid); end
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1) begin errors++; $display("FAIL pkt_valid3: got %b want 1", out_valid); end
        if (req !== 5'b0) begin errors++; $display("FAIL pkt_release: got %b want 00000", req); end
        @(negedge clk);
        checks++;
        if (req !== 5'b0 || out_valid !== 0) begin
            errors++;
            $display("FAIL pkt_relcycle: req=%b out_valid=%b want 00000 0", req, out_valid);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, c;
        logic [4:0]   first, second;
        int           phase, zeros;
        gnt_allow = '1;
        a = mk(T_SINGLE, 8'h31, 4'b0110);
        c = mk(T_SINGLE, 8'h32, 4'b0100);
        push_flit(a, 1'b1, a, 3'd3);
        push_flit(c, 1'b1, c, 3'd4);
        phase  = 0;
        zeros  = 0;
        first  = '0;
        second = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (phase == 0 && req != 5'b0) begin
                first = req;
                phase = 1;
            end else if (phase == 1 && req == 5'b0) begin
                zeros++;
            end else if (phase == 1 && req != first) begin
                second = req;
                phase  = 2;
            end
        end
        checks += 3;
        if (first !== 5'b01000) begin errors++; $display("FAIL b2b_first: got %b want 01000", first); end
        if (zeros < 1) begin errors++; $display("FAIL b2b_gap: got %0d low cycles want >=1", zeros); end
        if (second !== 5'b10000) begin
            errors++; $display("FAIL b2b_second: got %b want 10000", second);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] h, b, t;
        int k, nvalid;
        gnt_allow = '1;
        h = mk(T_HEAD, 8'h41, 4'b1001);
        b = mk(T_BODY, 8'h42, 4'b0000);
        t = mk(T_TAIL, 8'h43, 4'b0000);
        push_flit(h, 1'b1, h, 3'd1);
        k = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_head: no out_valid want 1"); end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 0 || req !== 5'b00010) begin
                errors++;
                $display("FAIL stall_empty: out_valid=%b req=%b want 0 00010", out_valid, req);
            end
        end
        gnt_allow = '0;
        push_flit(b, 1'b1, b, 3'd1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 0 || req !== 5'b00010) begin
                errors++;
                $display("FAIL stall_nogrant: out_valid=%b req=%b want 0 00010", out_valid, req);
            end
        end
        gnt_allow = '1;
        push_flit(t, 1'b1, t, 3'd1);
        nvalid = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid === 1'b1) nvalid++;
        end
        checks += 2;
        if (nvalid != 2) begin errors++; $display("FAIL stall_resume: got %0d flits want 2", nvalid); end
        if (req !== 5'b0) begin errors++; $display("FAIL stall_done: got %b want 00000", req); end
    endtask

    task automatic test_midhead();
        logic [W-1:0] h, s, t;
        int nperr, nvalid;
        gnt_allow = '1;
        h = mk(T_HEAD, 8'h51, 4'b0101);
        s = mk(T_SINGLE, 8'h52, 4'b1111);
        t = mk(T_TAIL, 8'h53, 4'b0000);
        push_flit(h, 1'b1, h, 3'd0);
        push_flit(s, 1'b1, mk(T_BODY, 8'h52, 4'b1111), 3'd0);
        push_flit(t, 1'b1, t, 3'd0);
        nperr  = 0;
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            if (protocol_err === 1'b1) nperr++;
            if (out_valid === 1'b1) nvalid++;
        end
        checks += 2;
        if (nperr != 1) begin errors++; $display("FAIL midhead_perr: got %0d pulses want 1", nperr); end
        if (nvalid != 3) begin errors++; $display("FAIL midhead_flits: got %0d want 3", nvalid); end
    endtask

    task automatic test_stray(input logic [1:0] ty, input logic [7:0] tag);
        int nperr, nreq, nvalid;
        gnt_allow = '1;
        push_flit(mk(ty, tag, 4'b1001), 1'b0, '0, 3'd0);
        nperr  = 0;
        nreq   = 0;
        nvalid = 0;
        repeat (10) begin
            @(negedge clk);
            if (protocol_err === 1'b1) nperr++;
            if (req !== 5'b0) nreq++;
            if (out_valid === 1'b1) nvalid++;
        end
        checks += 3;
        if (nperr != 1) begin errors++; $display("FAIL stray_perr: got %0d pulses want 1", nperr); end
        if (nreq != 0) begin errors++; $display("FAIL stray_req: got %0d req cycles want 0", nreq); end
        if (nvalid != 0) begin errors++; $display("FAIL stray_out: got %0d flits want 0", nvalid); end
    endtask

    task automatic test_fill_reset();
        int nbad;
        gnt_allow = '0;
        push_flit(mk(T_HEAD, 8'h61, 4'b0101), 1'b0, '0, 3'd0);
        push_flit(mk(T_BODY, 8'h62, 4'b0000), 1'b0, '0, 3'd0);
        push_flit(mk(T_BODY, 8'h63, 4'b0000), 1'b0, '0, 3'd0);
        push_flit(mk(T_BODY, 8'h64, 4'b0000), 1'b0, '0, 3'd0);
        @(negedge clk);
        checks += 3;
        if (in_ready !== 0) begin errors++; $display("FAIL fill_ready: got %b want 0", in_ready); end
        if (req !== 5'b00001) begin errors++; $display("FAIL fill_req: got %b want 00001", req); end
        if (out_valid !== 0) begin errors++; $display("FAIL fill_out: got %b want 0", out_valid); end
        rst      = 1'b0;
        in_valid = 1'b1;
        in_flit  = mk(T_SINGLE, 8'h65, 4'b0101);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (req !== 5'b0) begin errors++; $display("FAIL mrst_req: got %b want 00000", req); end
        if (out_valid !== 0) begin errors++; $display("FAIL mrst_out: got %b want 0", out_valid); end
        if (in_ready !== 1) begin errors++; $display("FAIL mrst_ready: got %b want 1", in_ready); end
        gnt_allow = '1;
        nbad = 0;
        repeat (10) begin
            @(negedge clk);
            if (req !== 5'b0 || out_valid !== 1'b0) nbad++;
        end
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL mrst_flushed: got %0d active cycles want 0", nbad); end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_flit   = '0;
        gnt_allow = '0;
        test_reset();
        test_single();
        test_packet();
        test_back_to_back();
        test_stall();
        test_midhead();
        test_stray(T_BODY, 8'h71);
        test_stray(T_TAIL, 8'h72);
        test_fill_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_flit_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d undelivered flits want 0", exp_flit_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
